// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, ALU control encodings, bus selects and sequencer states
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_SHR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_CMP = 3'b110;
   localparam logic [2:0] OP_NOP = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_AND   = 2'b01;
   localparam logic [1:0] ALUOP_XOR   = 2'b10;
   localparam logic [1:0] ALUOP_SHIFT = 2'b11;

   localparam logic [1:0] BUS_NONE = 2'b00;
   localparam logic [1:0] BUS_A    = 2'b01;
   localparam logic [1:0] BUS_B    = 2'b10;
   localparam logic [1:0] BUS_Y    = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_A,
      ST_EXEC,
      ST_DRIVE,
      ST_DONE
   } seqState_t;

endpackage

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - maps an op code to ALU sub/op controls and whether the result is driven
import alu_pkg::*;

module alu_seq_decode (
   input  logic [2:0] op,
   output logic       sub,
   output logic [1:0] aluOp,
   output logic       writesResult
);

   always_comb begin
      sub          = 1'b0;
      aluOp        = ALUOP_ADD;
      writesResult = 1'b1;
      case (op)
         OP_ADD: begin sub = 1'b0; aluOp = ALUOP_ADD;   end
         OP_SUB: begin sub = 1'b1; aluOp = ALUOP_ADD;   end
         OP_AND: begin sub = 1'b0; aluOp = ALUOP_AND;   end
         OP_XOR: begin sub = 1'b0; aluOp = ALUOP_XOR;   end
         OP_SHR: begin sub = 1'b0; aluOp = ALUOP_SHIFT; end
         OP_SHL: begin sub = 1'b1; aluOp = ALUOP_SHIFT; end
         // CMP only updates flags; its result never reaches the bus
         OP_CMP: begin sub = 1'b1; aluOp = ALUOP_ADD; writesResult = 1'b0; end
         default: begin sub = 1'b0; aluOp = ALUOP_ADD; writesResult = 1'b0; end
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - operand/control sequencer for the 8-bit ALU with bus wait states and timeout
import alu_pkg::*;

module alu_seq #(
   parameter int TIMEOUT = 15
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [2:0] i_op,
   input  logic [7:0] i_bus,
   input  logic       i_busValid,
   output logic [1:0] o_busReq,
   output logic [7:0] o_a,
   output logic       o_ctrlAluYNWE,
   output logic       o_ctrlAluNOE,
   output logic       o_ctrlAluSub,
   output logic [1:0] o_ctrlAluOp,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_error
);

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   seqState_t  state;
   logic [2:0] opReg;
   logic [7:0] waitCnt;

   logic [2:0] decIn;
   logic       decSub;
   logic [1:0] decAluOp;
   logic       decWrites;

   // In IDLE the incoming op is decoded so Sub/Op are valid from the first busy cycle
   assign decIn = (state == ST_IDLE) ? i_op : opReg;

   alu_seq_decode u_decode (
      .op           (decIn),
      .sub          (decSub),
      .aluOp        (decAluOp),
      .writesResult (decWrites)
   );

   // The ALU must capture on the same edge the B operand is valid, so this strobe is combinational
   assign o_ctrlAluYNWE = !((state == ST_EXEC) && i_busValid);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state        <= ST_IDLE;
         opReg        <= OP_ADD;
         waitCnt      <= 8'd0;
         o_a          <= 8'd0;
         o_busReq     <= BUS_NONE;
         o_ctrlAluNOE <= 1'b1;
         o_ctrlAluSub <= 1'b0;
         o_ctrlAluOp  <= ALUOP_ADD;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_error      <= 1'b0;
      end else begin
         o_done  <= 1'b0;
         o_error <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  opReg        <= i_op;
                  waitCnt      <= 8'd0;
                  o_busy       <= 1'b1;
                  o_ctrlAluSub <= decSub;
                  o_ctrlAluOp  <= decAluOp;
                  if (i_op == OP_NOP) begin
                     state    <= ST_DONE;
                     o_busReq <= BUS_NONE;
                     o_done   <= 1'b1;
                  end else begin
                     state    <= ST_LOAD_A;
                     o_busReq <= BUS_A;
                  end
               end
            end
            ST_LOAD_A: begin
               if (i_busValid) begin
                  o_a      <= i_bus;
                  waitCnt  <= 8'd0;
                  state    <= ST_EXEC;
                  o_busReq <= BUS_B;
               end else if (waitCnt == WAIT_LAST) begin
                  waitCnt  <= waitCnt + 8'd1;
                  state    <= ST_DONE;
                  o_busReq <= BUS_NONE;
                  o_done   <= 1'b1;
                  o_error  <= 1'b1;
               end else begin
                  waitCnt <= waitCnt + 8'd1;
               end
            end
            ST_EXEC: begin
               if (i_busValid) begin
                  if (decWrites) begin
                     state        <= ST_DRIVE;
                     o_busReq     <= BUS_Y;
                     o_ctrlAluNOE <= 1'b0;
                  end else begin
                     state    <= ST_DONE;
                     o_busReq <= BUS_NONE;
                     o_done   <= 1'b1;
                  end
               end else if (waitCnt == WAIT_LAST) begin
                  waitCnt  <= waitCnt + 8'd1;
                  state    <= ST_DONE;
                  o_busReq <= BUS_NONE;
                  o_done   <= 1'b1;
                  o_error  <= 1'b1;
               end else begin
                  waitCnt <= waitCnt + 8'd1;
               end
            end
            ST_DRIVE: begin
               state        <= ST_DONE;
               o_busReq     <= BUS_NONE;
               o_ctrlAluNOE <= 1'b1;
               o_done       <= 1'b1;
            end
            ST_DONE: begin
               state        <= ST_IDLE;
               o_busReq     <= BUS_NONE;
               o_busy       <= 1'b0;
               o_ctrlAluSub <= 1'b0;
               o_ctrlAluOp  <= ALUOP_ADD;
            end
            default: begin
               state        <= ST_IDLE;
               o_busReq     <= BUS_NONE;
               o_ctrlAluNOE <= 1'b1;
               o_busy       <= 1'b0;
               o_ctrlAluSub <= 1'b0;
               o_ctrlAluOp  <= ALUOP_ADD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed cycle-by-cycle checks of the ALU operand sequencer
module tb_alu_seq;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic       i_start;
   logic [2:0] i_op;
   logic [7:0] i_bus;
   logic       i_busValid;
   logic [1:0] o_busReq;
   logic [7:0] o_a;
   logic       o_ctrlAluYNWE;
   logic       o_ctrlAluNOE;
   logic       o_ctrlAluSub;
   logic [1:0] o_ctrlAluOp;
   logic       o_busy;
   logic       o_done;
   logic       o_error;

   int checks = 0;
   int errors = 0;

   alu_seq #(.TIMEOUT(4)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_start       (i_start),
      .i_op          (i_op),
      .i_bus         (i_bus),
      .i_busValid    (i_busValid),
      .o_busReq      (o_busReq),
      .o_a           (o_a),
      .o_ctrlAluYNWE (o_ctrlAluYNWE),
      .o_ctrlAluNOE  (o_ctrlAluNOE),
      .o_ctrlAluSub  (o_ctrlAluSub),
      .o_ctrlAluOp   (o_ctrlAluOp),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_error       (o_error)
   );

   always #5 i_clk = ~i_clk;

   task automatic drive(input logic start, input logic [2:0] op, input logic valid, input logic [7:0] bus);
      @(negedge i_clk);
      i_start    = start;
      i_op       = op;
      i_busValid = valid;
      i_bus      = bus;
      #1;
   endtask

   // expected order: busReq, YNWE, NOE, Sub, Op, busy, done, error
   task automatic expectOut(input string tag, input logic [1:0] busReq, input logic ynwe, input logic noe,
                            input logic sub, input logic [1:0] aluOp, input logic busy, input logic done,
                            input logic err);
      logic [9:0] obs;
      logic [9:0] exp;
      obs = {o_busReq, o_ctrlAluYNWE, o_ctrlAluNOE, o_ctrlAluSub, o_ctrlAluOp, o_busy, o_done, o_error};
      exp = {busReq, ynwe, noe, sub, aluOp, busy, done, err};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b (busReq,ynwe,noe,sub,op,busy,done,err)", tag, obs, exp);
      end
   endtask

   task automatic expectA(input string tag, input logic [7:0] exp);
      checks++;
      assert (o_a === exp) else begin
         errors++;
         $error("FAIL %s: observed o_a=%h expected %h", tag, o_a, exp);
      end
   endtask

   initial begin
      i_reset    = 1'b1;
      i_start    = 1'b0;
      i_op       = 3'b000;
      i_bus      = 8'h00;
      i_busValid = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      expectOut("reset", 2'b00, 1, 1, 0, 2'b00, 0, 0, 0);
      expectA("reset_a", 8'h00);
      i_reset = 1'b0;

      // ADD 0x05 + 0x03, valid always high
      drive(1, 3'b000, 1, 8'h00); expectOut("add_c0", 2'b00, 1, 1, 0, 2'b00, 0, 0, 0);
      drive(0, 3'b000, 1, 8'h05); expectOut("add_c1", 2'b01, 1, 1, 0, 2'b00, 1, 0, 0);
      drive(0, 3'b000, 1, 8'h03); expectOut("add_c2", 2'b10, 0, 1, 0, 2'b00, 1, 0, 0);
      expectA("add_a", 8'h05);
      drive(0, 3'b000, 0, 8'h00); expectOut("add_c3", 2'b11, 1, 0, 0, 2'b00, 1, 0, 0);
      drive(0, 3'b000, 0, 8'h00); expectOut("add_c4", 2'b00, 1, 1, 0, 2'b00, 1, 1, 0);
      drive(0, 3'b000, 0, 8'h00); expectOut("add_c5", 2'b00, 1, 1, 0, 2'b00, 0, 0, 0);

      // SHL 0x81 by 0x01
      drive(1, 3'b101, 1, 8'h00); expectOut("shl_c0", 2'b00, 1, 1, 0, 2'b00, 0, 0, 0);
      drive(0, 3'b000, 1, 8'h81); expectOut("shl_c1", 2'b01, 1, 1, 1, 2'b11, 1, 0, 0);
      drive(0, 3'b000, 1, 8'h01); expectOut("shl_c2", 2'b10, 0, 1, 1, 2'b11, 1, 0, 0);
      expectA("shl_a", 8'h81);
      drive(0, 3'b000, 0, 8'h00); expectOut("shl_c3", 2'b11, 1, 0, 1, 2'b11, 1, 0, 0);
      drive(0, 3'b000, 0, 8'h00); expectOut("shl_c4", 2'b00, 1, 1, 1, 2'b11, 1, 1, 0);
      drive(0, 3'b000, 0, 8'h00); expectOut("shl_c5", 2'b00, 1, 1, 0, 2'b00, 0, 0, 0);

      // CMP 0x10 vs 0x10: flags written, no DRIVE
      drive(1, 3'b110, 1, 8'h00); expectOut("cmp_c0", 2'b00, 1, 1, 0, 2'b00, 0, 0, 0);
      drive(0, 3'b000, 1, 8'h10); expectOut("cmp_c1", 2'b01, 1, 1, 1, 2'b00, 1, 0, 0);
      drive(0, 3'b000, 1, 8'h10); expectOut("cmp_c2", 2'b10, 0, 1, 1, 2'b00, 1, 0, 0);
      drive(0, 3'b000, 1, 8'h00); expectOut("cmp_c3", 2'b00, 1, 1, 1, 2'b00, 1, 1, 0);
      drive(0, 3'b000, 0, 8'h00); expectOut("cmp_c4", 2'b00, 1, 1, 0, 2'b00, 0, 0, 0);

      // NOP completes the cycle after start
      drive(1, 3'b111, 1, 8'h00); expectOut("nop_c0", 2'b00, 1, 1, 0, 2'b00, 0, 0, 0);
      drive(0, 3'b000, 1, 8'h00); expectOut("nop_c1", 2'b00, 1, 1, 0, 2'b00, 1, 1, 0);
      drive(0, 3'b000, 0, 8'h00); expectOut("nop_c2", 2'b00, 1, 1, 0, 2'b00, 0, 0, 0);
      expectA("nop_a", 8'h10);

      // ADD 0x7F + 0x01 with 3 wait cycles in LOAD_A and 2 in EXEC
      drive(1, 3'b000, 0, 8'h00); expectOut("ws_c0", 2'b00, 1, 1, 0, 2'b00, 0, 0, 0);
      drive(0, 3'b000, 0, 8'h7F); expectOut("ws_c1", 2'b01, 1, 1, 0, 2'b00, 1, 0, 0);
      drive(0, 3'b000, 0, 8'h7F); expectOut("ws_c2", 2'b01, 1, 1, 0, 2'b00, 1, 0, 0);
      drive(0, 3'b000, 0, 8'h7F); expectOut("ws_c3", 2'b01, 1, 1, 0, 2'b00, 1, 0, 0);
      expectA("ws_a_hold", 8'h10);
      drive(0, 3'b000, 1, 8'h7F); expectOut("ws_c4", 2'b01, 1, 1, 0, 2'b00, 1, 0, 0);
      drive(0, 3'b000, 0, 8'h01); expectOut("ws_c5", 2'b10, 1, 1, 0, 2'b00, 1, 0, 0);
      expectA("ws_a", 8'h7F);
      drive(0, 3'b000, 0, 8'h01); expectOut("ws_c6", 2'b10, 1, 1, 0, 2'b00, 1, 0, 0);
      drive(0, 3'b000, 1, 8'h01); expectOut("ws_c7", 2'b10, 0, 1, 0, 2'b00, 1, 0, 0);
      drive(0, 3'b000, 0, 8'h00); expectOut("ws_c8", 2'b11, 1, 0, 0, 2'b00, 1, 0, 0);
      drive(0, 3'b000, 0, 8'h00); expectOut("ws_c9", 2'b00, 1, 1, 0, 2'b00, 1, 1, 0);
      drive(0, 3'b000, 0, 8'h00); expectOut("ws_c10", 2'b00, 1, 1, 0, 2'b00, 0, 0, 0);

      // Timeout in LOAD_A after 4 wait cycles
      drive(1, 3'b000, 0, 8'h00); expectOut("toA_c0", 2'b00, 1, 1, 0, 2'b00, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         drive(0, 3'b000, 0, 8'hEE); expectOut($sformatf("toA_c%0d", i), 2'b01, 1, 1, 0, 2'b00, 1, 0, 0);
      end
      drive(0, 3'b000, 0, 8'h00); expectOut("toA_c5", 2'b00, 1, 1, 0, 2'b00, 1, 1, 1);
      expectA("toA_a", 8'h7F);
      drive(0, 3'b000, 0, 8'h00); expectOut("toA_c6", 2'b00, 1, 1, 0, 2'b00, 0, 0, 0);

      // XOR: one LOAD_A wait, then timeout in EXEC; counter restarts per phase
      drive(1, 3'b011, 0, 8'h00); expectOut("toB_c0", 2'b00, 1, 1, 0, 2'b00, 0, 0, 0);
      drive(0, 3'b000, 0, 8'h22); expectOut("toB_c1", 2'b01, 1, 1, 0, 2'b10, 1, 0, 0);
      drive(0, 3'b000, 1, 8'h22); expectOut("toB_c2", 2'b01, 1, 1, 0, 2'b10, 1, 0, 0);
      for (int i = 3; i <= 6; i++) begin
         drive(0, 3'b000, 0, 8'h33); expectOut($sformatf("toB_c%0d", i), 2'b10, 1, 1, 0, 2'b10, 1, 0, 0);
      end
      drive(0, 3'b000, 0, 8'h00); expectOut("toB_c7", 2'b00, 1, 1, 0, 2'b10, 1, 1, 1);
      expectA("toB_a", 8'h22);
      drive(0, 3'b000, 0, 8'h00); expectOut("toB_c8", 2'b00, 1, 1, 0, 2'b00, 0, 0, 0);

      // Second start while busy is ignored; reset in EXEC returns to reset values
      drive(1, 3'b001, 1, 8'h00); expectOut("rst_c0", 2'b00, 1, 1, 0, 2'b00, 0, 0, 0);
      drive(1, 3'b111, 1, 8'h55); expectOut("rst_c1", 2'b01, 1, 1, 1, 2'b00, 1, 0, 0);
      drive(0, 3'b000, 0, 8'h66); expectOut("rst_c2", 2'b10, 1, 1, 1, 2'b00, 1, 0, 0);
      expectA("rst_a_pre", 8'h55);
      i_reset = 1'b1;
      drive(0, 3'b000, 0, 8'h00);
      i_reset = 1'b0;
      expectOut("rst_c3", 2'b00, 1, 1, 0, 2'b00, 0, 0, 0);
      expectA("rst_a", 8'h00);
      drive(0, 3'b000, 1, 8'h00); expectOut("rst_c4", 2'b00, 1, 1, 0, 2'b00, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Operand/control sequencer sitting directly upstream of the 8-bit ALU. It accepts an ALU operation request and holds operand A in its own register, which drives the ALU's A input. It steps the shared bus through two operand phases, generates the ALU control strobes (Y write, output enable, sub, op), and signals completion. A wait-state handshake on the bus, with a timeout, makes it tolerant of slow bus sources.

Parameters:
TIMEOUT, 15, max cycles spent waiting for i_busValid in one operand phase before aborting (1..255).

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_start  in  1  request pulse; sampled only in IDLE
i_op  in  3  operation code, latched with i_start
i_bus  in  8  shared data bus
i_busValid  in  1  bus source has placed the requested data on i_bus this cycle
o_busReq  out  2  bus source select: 00 none, 01 operand A, 10 operand B, 11 ALU result
o_a  out  8  operand A register, wired to ALU i_a
o_ctrlAluYNWE  out  1  active-low ALU result/flag write strobe
o_ctrlAluNOE  out  1  active-low ALU bus output enable
o_ctrlAluSub  out  1  ALU sub/reverse control
o_ctrlAluOp  out  2  ALU op select
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle completion pulse
o_error  out  1  one-cycle timeout pulse, coincident with o_done

Behaviour:
- Clock and reset: reset i_reset, synchronous, active-high; clock i_clk.
- Reset values: state IDLE, o_a=0, op register=000, wait counter=0, o_busReq=00, YNWE=1, NOE=1, Sub=0, Op=00, busy/done/error=0.
- Reset has priority over every transition, including mid-operation. The next cycle shows all strobes inactive.
- Op decode (Sub, Op):
  - 000 ADD (0,00)
  - 001 SUB (1,00)
  - 010 AND (0,01)
  - 011 XOR (0,10)
  - 100 SHR (0,11)
  - 101 SHL (1,11)
  - 110 CMP (1,00, result not driven)
  - 111 NOP
- Sub/Op are driven from the latched op in all states except IDLE; they are 0/00 in IDLE.
- States:
  - IDLE: on i_start, latch i_op, clear counter. Go to DONE for NOP, else LOAD_A. Extra i_start pulses while busy are ignored.
  - LOAD_A: o_busReq=01. When i_busValid=1, capture i_bus into o_a on that edge, clear counter, go to EXEC.
  - EXEC: o_busReq=10. o_ctrlAluYNWE = !i_busValid, combinational, so the ALU captures on the same edge. When i_busValid=1, go to DRIVE, or to DONE for CMP.
  - DRIVE: o_busReq=11, o_ctrlAluNOE=0 for exactly one cycle, then DONE.
  - DONE: o_done=1 for one cycle, o_busReq=00, then IDLE.
- Wait counter: increments each cycle that LOAD_A or EXEC sees i_busValid=0. When it reaches TIMEOUT, go to DONE with o_error=1. YNWE is never asserted on the abort path, and o_a keeps its last captured value.
- Counter width is 8 bits and it never wraps; abort occurs first.
- Latency with i_busValid always high: start at cycle 0 → LOAD_A 1, EXEC 2, DRIVE 3, done 4. CMP gives done at cycle 3; NOP gives done at cycle 1.
- o_ctrlAluYNWE and o_ctrlAluNOE are never low in the same cycle. NOE is low only in DRIVE.

Decomposition:
- Shared package alu_pkg holds:
  - op codes OP_ADD..OP_NOP (3-bit)
  - ALU op constants ALUOP_ADD=00, AND=01, XOR=10, SHIFT=11
  - bus-select constants BUS_NONE/A/B/Y
  - the state enum
- One natural sub-module, alu_seq_decode: a combinational map from op to {sub, aluOp, writesResult}, reused by the microcode block.
- FSM, counter and A register stay in alu_seq.

Test Plan:
- ADD, valid always high; i_op=000, A=0x05, B=0x03 → o_a=0x05 at cycle 2. YNWE low only in cycle 2 with Sub=0, Op=00. NOE low only in cycle 3. o_done at cycle 4; ALU bus reads 0x08.
- SHL i_op=101, A=0x81, B=0x01 → Sub=1, Op=11 during EXEC; ALU result 0x02. o_done at cycle 4 with o_error=0.
- CMP i_op=110, A=0x10, B=0x10 → YNWE pulse in EXEC, NOE never low, o_done at cycle 3.
- Wait states: i_busValid low 3 cycles in LOAD_A and 2 in EXEC, ADD 0x7F+0x01 → o_a captured only on a valid cycle. YNWE is low only on the valid EXEC cycle, and o_done occurs 5 cycles later than the nominal case.
- Timeout, TIMEOUT=4, i_busValid stuck low → o_done=o_error=1 after 4 LOAD_A wait cycles. YNWE and NOE stay high throughout; then IDLE.
- Reset asserted in EXEC, plus a second i_start while busy → reset gives IDLE with all outputs at reset values on the next cycle. A start pulse during busy produces no second operation.
